sorted_block_serializer: RTL and testbench
==========================================

Name: sorted_block_serializer

Overview:
- Drain-side companion to the EVEN_ODD sorting network.
- Captures one full sorted block (2^P_LOG records, presented in parallel with a one-cycle DOTEN-style strobe) and streams it out as 2^W_LOG records per beat under a valid/ready handshake.
- Sits between the sorter output and narrow downstream logic such as a merger, FIFO or memory writer.
- Two-entry block buffer absorbs sorter bursts while downstream applies backpressure.

Parameters:
- P_LOG, 9, log2 of records per block.
- W_LOG, 2, log2 of records per output beat; 0 <= W_LOG <= P_LOG.
- DATW, 64, record width in bits (payload + key).
- KEYW, 32, key width; key occupies record bits [KEYW-1:0]; unsigned.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- DIN  in  DATW<<P_LOG  sorted block; record i at [DATW*(i+1)-1:DATW*i].
- DINEN  in  1  one-cycle strobe, DIN valid.
- DOT  out  DATW<<W_LOG  output beat; record j of beat at [DATW*(j+1)-1:DATW*j].
- DOTEN  out  1  beat valid.
- DOT_RDY  in  1  downstream ready.
- FULL  out  1  both block buffers occupied.
- OVF  out  1  sticky: block dropped.
- ORDER_ERR  out  1  sticky key-order error (see Optional Feature).

Behaviour:
- Clock and reset: one clock CLK. Reset RST is synchronous, active-high. All state lives on the CLK edge.
- Reset values: cnt=0, wp=0, rp=0, beat=0, OVF=0, ORDER_ERR=0, DOTEN=0, DOT=0, FULL=0. Buffer contents are not reset.
- State:
  - cnt in {0,1,2}: EMPTY, ONE, TWO.
  - wp, rp: 1-bit slot pointers.
  - beat: counter of width P_LOG-W_LOG; one-bit constant 0 if P_LOG==W_LOG.
- Capture: on an edge with DINEN=1:
  - if cnt<2, or the last beat of buf[rp] is being transferred that same edge: buf[wp]<=DIN, wp flips.
  - otherwise: block dropped, OVF<=1, buffers unchanged.
- Output drive (registered state only; no combinational path DOT_RDY->DOTEN):
  - DOTEN = (cnt!=0).
  - DOT = records [beat<<W_LOG .. (beat<<W_LOG)+2^W_LOG-1] of buf[rp].
  - DOT = 0 when DOTEN=0.
- Transfer: occurs on an edge where DOTEN && DOT_RDY.
  - beat increments.
  - On the last beat (beat == 2^(P_LOG-W_LOG)-1): beat<=0, rp flips, block released.
- cnt update: +1 on capture only; -1 on release only; unchanged on both or neither.
- Simultaneous capture and release at cnt=2: the write goes into the slot being released (wp==rp). The last beat is read from the pre-edge contents. Legal; OVF stays 0.
- Latency:
  - DINEN sampled at edge k with cnt=0 -> DOTEN=1 with beat 0 from cycle k+1.
  - With DOT_RDY held 1, a block drains in 2^(P_LOG-W_LOG) cycles; back-to-back blocks stream with no bubble.
- DOT_RDY=0: DOT/DOTEN hold stable; beat does not advance.
- FULL = (cnt==2), registered.
- OVF and ORDER_ERR clear only on RST.
- Reset mid-operation: pending blocks are discarded; outputs return to reset values the cycle after RST is sampled.

Optional Feature:
- Macro: SERIALIZER_ORDER_CHECK_EN.
- Defined:
  - Unsigned-compares each emitted record key with the previously emitted key of the same block, including across beat boundaries. The last key of each transferred beat is held in a KEYW-bit register.
  - Sets ORDER_ERR<=1 on any strict decrease. Evaluated only on transfer edges.
  - Comparison state resets at beat 0 of each block.
- Not defined: no checker logic; ORDER_ERR tied 0.

Test Plan (P_LOG=3, W_LOG=1, DATW=16, KEYW=8, keys 1..8 ascending, payloads 8..1):
- Single block, DINEN one cycle, DOT_RDY=1 -> DOTEN from next cycle for 4 beats; keys (1,2),(3,4),(5,6),(7,8); then DOTEN=0, DOT=0.
- Backpressure: DOT_RDY toggled 1,0,0,1,... -> each beat held stable while DOT_RDY=0; exactly 4 transfers in order; no duplicates or skips.
- Three blocks on consecutive cycles, DOT_RDY=0 -> FULL=1 after the second; third dropped, OVF=1. Releasing DOT_RDY yields blocks 1 and 2 only (8 beats).
- cnt=2, DINEN coincides with last-beat transfer of block A -> OVF=0, FULL stays 1; subsequent beats are block B, then the new block C.
- RST asserted mid-block (beat 2) -> next cycle DOTEN=0, FULL=0, OVF=0; a fresh block after reset starts at beat 0.
- With SERIALIZER_ORDER_CHECK_EN: a block with keys 1,2,3,5,4,6,7,8 -> ORDER_ERR=1 after beat 2 transfers. Ascending block -> ORDER_ERR stays 0.

Source files
------------

// File: rtl/sorted_block_serializer.sv
// Captures one sorted block into a two-slot buffer and drains it 2^W_LOG records per beat.
// Optional key-order checker enabled by defining SERIALIZER_ORDER_CHECK_EN.
module sorted_block_serializer #(
   parameter int P_LOG = 9,
   parameter int W_LOG = 2,
   parameter int DATW  = 64,
   parameter int KEYW  = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [(DATW<<P_LOG)-1:0] DIN,
   input  logic                     DINEN,
   output logic [(DATW<<W_LOG)-1:0] DOT,
   output logic                     DOTEN,
   input  logic                     DOT_RDY,
   output logic                     FULL,
   output logic                     OVF,
   output logic                     ORDER_ERR
);

   localparam int BLKW  = DATW << P_LOG;
   localparam int BEATW = DATW << W_LOG;
   localparam int NREC  = 1 << W_LOG;
   localparam int NBEAT = 1 << (P_LOG - W_LOG);
   localparam int BW    = (P_LOG == W_LOG) ? 1 : P_LOG - W_LOG;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

   logic [BLKW-1:0]  r_buf [2];
   logic [1:0]       r_cnt;
   logic             r_wp;
   logic             r_rp;
   logic [BW-1:0]    r_beat;
   logic             r_doten;
   logic             r_full;
   logic             r_ovf;

   logic             w_xfer;
   logic             w_last;
   logic             w_release;
   logic             w_capture;
   logic [1:0]       w_cnt_next;
   logic [BLKW-1:0]  w_blk;
   logic [BEATW-1:0] w_beat_data;

   if (KEYW > DATW || W_LOG > P_LOG || W_LOG < 0) begin : g_param_check
      $error("sorted_block_serializer: illegal KEYW/W_LOG/P_LOG combination");
   end

   assign w_xfer     = r_doten & DOT_RDY;
   assign w_last     = (r_beat == LAST_BEAT);
   assign w_release  = w_xfer & w_last;
   // A full buffer still accepts a block when the slot it would overwrite drains this edge.
   assign w_capture  = DINEN & ((r_cnt != 2'd2) | w_release);
   assign w_cnt_next = r_cnt + {1'b0, w_capture} - {1'b0, w_release};

   assign w_blk = r_buf[r_rp];

   generate
      if (P_LOG == W_LOG) begin : g_one_beat
         assign w_beat_data = w_blk;
      end else begin : g_multi_beat
         logic [BEATW-1:0] w_beats [NBEAT];
         for (genvar gi = 0; gi < NBEAT; gi++) begin : g_split
            assign w_beats[gi] = w_blk[gi*BEATW +: BEATW];
         end
         assign w_beat_data = w_beats[r_beat];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!RST && w_capture) begin
         r_buf[r_wp] <= DIN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt   <= 2'd0;
         r_wp    <= 1'b0;
         r_rp    <= 1'b0;
         r_beat  <= '0;
         r_doten <= 1'b0;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_next;
         r_doten <= (w_cnt_next != 2'd0);
         r_full  <= (w_cnt_next == 2'd2);
         if (w_capture) begin
            r_wp <= ~r_wp;
         end else if (DINEN) begin
            r_ovf <= 1'b1;
         end
         if (w_xfer) begin
            if (w_last) begin
               r_beat <= '0;
               r_rp   <= ~r_rp;
            end else begin
               r_beat <= r_beat + 1'b1;
            end
         end
      end
   end

   assign DOTEN = r_doten;
   assign DOT   = r_doten ? w_beat_data : '0;
   assign FULL  = r_full;
   assign OVF   = r_ovf;

`ifdef SERIALIZER_ORDER_CHECK_EN
   logic [KEYW-1:0] r_last_key;
   logic            r_order_err;
   logic [KEYW-1:0] w_keys [NREC];
   logic [NREC-1:0] w_dec;

   generate
      for (genvar gi = 0; gi < NREC; gi++) begin : g_keys
         assign w_keys[gi] = w_beat_data[gi*DATW +: KEYW];
         if (gi == 0) begin : g_first
            // The first record of a block has no predecessor to compare against.
            assign w_dec[gi] = (r_beat != '0) && (w_keys[gi] < r_last_key);
         end else begin : g_rest
            assign w_dec[gi] = (w_keys[gi] < w_keys[gi-1]);
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_last_key  <= '0;
         r_order_err <= 1'b0;
      end else if (w_xfer) begin
         if (|w_dec) begin
            r_order_err <= 1'b1;
         end
         r_last_key <= w_keys[NREC-1];
      end
   end

   assign ORDER_ERR = r_order_err;
`else
   assign ORDER_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_block_serializer.sv
// Directed bench for sorted_block_serializer at P_LOG=3, W_LOG=1, DATW=16, KEYW=8.
// Checks ORDER_ERR behaviour for whichever build SERIALIZER_ORDER_CHECK_EN selects.
module tb_sorted_block_serializer;

   localparam int P_LOG = 3;
   localparam int W_LOG = 1;
   localparam int DATW  = 16;
   localparam int KEYW  = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [127:0] DIN = '0;
   logic         DINEN = 1'b0;
   logic         DOT_RDY = 1'b0;
   logic [31:0]  DOT;
   logic         DOTEN;
   logic         FULL;
   logic         OVF;
   logic         ORDER_ERR;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   sorted_block_serializer #(
      .P_LOG(P_LOG), .W_LOG(W_LOG), .DATW(DATW), .KEYW(KEYW)
   ) dut (
      .CLK(CLK), .RST(RST), .DIN(DIN), .DINEN(DINEN),
      .DOT(DOT), .DOTEN(DOTEN), .DOT_RDY(DOT_RDY),
      .FULL(FULL), .OVF(OVF), .ORDER_ERR(ORDER_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Record i = {tag, 8-i, key_i}: payload tag*16 + (8-i), key from the keys byte lane i.
   function automatic logic [127:0] mk_blk(input logic [3:0] tag, input logic [63:0] keys);
      logic [127:0] b;
      for (int i = 0; i < 8; i++) begin
         b[16*i +: 16] = {tag, 4'(8 - i), keys[8*i +: 8]};
      end
      return b;
   endfunction

   function automatic logic [31:0] beat_of(input logic [127:0] blk, input int b);
      return blk[32*b +: 32];
   endfunction

   localparam logic [63:0] KEYS_UP  = 64'h0807060504030201;
   localparam logic [63:0] KEYS_BAD = 64'h0807060405030201;
`ifdef SERIALIZER_ORDER_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic [31:0]  exp_a [4];
   logic [127:0] blk_a, blk_1, blk_2, blk_3, blk_bad;
   int           pat [12];
   int           eb;

   initial begin
      exp_a   = '{32'h07020801, 32'h05040603, 32'h03060405, 32'h01080207};
      pat     = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
      blk_a   = mk_blk(4'd0, KEYS_UP);
      blk_1   = mk_blk(4'd1, KEYS_UP);
      blk_2   = mk_blk(4'd2, KEYS_UP);
      blk_3   = mk_blk(4'd3, KEYS_UP);
      blk_bad = mk_blk(4'd0, KEYS_BAD);

      // Reset state
      step();
      step();
      chk("rst_doten", 32'(DOTEN), 32'd0);
      chk("rst_dot", DOT, 32'd0);
      chk("rst_full", 32'(FULL), 32'd0);
      chk("rst_ovf", 32'(OVF), 32'd0);
      chk("rst_order_err", 32'(ORDER_ERR), 32'd0);
      RST = 1'b0;
      step();

      // Single block, free-running drain
      DOT_RDY = 1'b1;
      DIN = blk_a;
      DINEN = 1'b1;
      step();
      DINEN = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("t1_doten%0d", b), 32'(DOTEN), 32'd1);
         chk($sformatf("t1_beat%0d", b), DOT, exp_a[b]);
         step();
      end
      chk("t1_doten_end", 32'(DOTEN), 32'd0);
      chk("t1_dot_end", DOT, 32'd0);
      chk("t1_order_err", 32'(ORDER_ERR), 32'd0);

      // Backpressure with ready pattern 1,0,0,1,...
      DOT_RDY = 1'b0;
      DIN = blk_a;
      DINEN = 1'b1;
      step();
      DINEN = 1'b0;
      eb = 0;
      for (int c = 0; c < 12; c++) begin
         DOT_RDY = pat[c][0];
         if (eb < 4) begin
            chk($sformatf("t2_doten_c%0d", c), 32'(DOTEN), 32'd1);
            chk($sformatf("t2_dot_c%0d", c), DOT, exp_a[eb]);
         end else begin
            chk($sformatf("t2_doten_c%0d", c), 32'(DOTEN), 32'd0);
            chk($sformatf("t2_dot_c%0d", c), DOT, 32'd0);
         end
         step();
         if (pat[c] != 0 && eb < 4) eb++;
      end

      // Three blocks back to back while stalled: third is dropped
      DOT_RDY = 1'b0;
      DIN = blk_1;
      DINEN = 1'b1;
      step();
      chk("t3_full_one", 32'(FULL), 32'd0);
      DIN = blk_2;
      step();
      chk("t3_full_two", 32'(FULL), 32'd1);
      DIN = blk_3;
      step();
      DINEN = 1'b0;
      chk("t3_ovf", 32'(OVF), 32'd1);
      chk("t3_full_hold", 32'(FULL), 32'd1);
      DOT_RDY = 1'b1;
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("t3_beat%0d", b), DOT, beat_of((b < 4) ? blk_1 : blk_2, b % 4));
         step();
      end
      chk("t3_doten_end", 32'(DOTEN), 32'd0);
      chk("t3_ovf_sticky", 32'(OVF), 32'd1);

      // Reset mid-block with both slots occupied
      DOT_RDY = 1'b0;
      DIN = blk_a;
      DINEN = 1'b1;
      step();
      DIN = blk_2;
      step();
      DINEN = 1'b0;
      DOT_RDY = 1'b1;
      step();
      step();
      chk("t5_pre_beat2", DOT, exp_a[2]);
      chk("t5_pre_full", 32'(FULL), 32'd1);
      RST = 1'b1;
      step();
      chk("t5_doten", 32'(DOTEN), 32'd0);
      chk("t5_full", 32'(FULL), 32'd0);
      chk("t5_ovf", 32'(OVF), 32'd0);
      chk("t5_dot", DOT, 32'd0);
      RST = 1'b0;
      DIN = blk_3;
      DINEN = 1'b1;
      step();
      DINEN = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("t5_fresh_beat%0d", b), DOT, beat_of(blk_3, b));
         step();
      end
      chk("t5_doten_end", 32'(DOTEN), 32'd0);

      // Capture coinciding with the last-beat release at cnt=2
      DOT_RDY = 1'b0;
      DIN = blk_1;
      DINEN = 1'b1;
      step();
      DIN = blk_2;
      step();
      DINEN = 1'b0;
      chk("t4_full", 32'(FULL), 32'd1);
      DOT_RDY = 1'b1;
      for (int b = 0; b < 3; b++) begin
         chk($sformatf("t4_a_beat%0d", b), DOT, beat_of(blk_1, b));
         step();
      end
      DIN = blk_3;
      DINEN = 1'b1;
      chk("t4_a_beat3", DOT, beat_of(blk_1, 3));
      step();
      DINEN = 1'b0;
      chk("t4_ovf", 32'(OVF), 32'd0);
      chk("t4_full_hold", 32'(FULL), 32'd1);
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("t4_bc_beat%0d", b), DOT, beat_of((b < 4) ? blk_2 : blk_3, b % 4));
         step();
      end
      chk("t4_doten_end", 32'(DOTEN), 32'd0);
      chk("t4_full_end", 32'(FULL), 32'd0);
      chk("t4_order_err", 32'(ORDER_ERR), 32'd0);

      // Key-order error in beat 2 (keys 1,2,3,5,4,6,7,8)
      DOT_RDY = 1'b1;
      DIN = blk_bad;
      DINEN = 1'b1;
      step();
      DINEN = 1'b0;
      step();
      step();
      chk("t6_err_after_beat1", 32'(ORDER_ERR), 32'd0);
      step();
      chk("t6_err_after_beat2", 32'(ORDER_ERR), 32'(EXP_ERR));
      step();
      chk("t6_doten_end", 32'(DOTEN), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
